// File: rtl/fft_bram_addr_gen.sv
// fft_bram_addr_gen: bit-reversed sample loader and radix-2 DIT
// butterfly address/twiddle sequencer for an in-place FFT BRAM.
module fft_bram_addr_gen #(
    parameter  int DATA_WIDTH = 18,
    parameter  int LOG2N      = 10,
    parameter  int STAGE_GAP  = 4,
    localparam int STG_W      = (LOG2N > 2) ? $clog2(LOG2N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic                  o_we,
    output logic [LOG2N-1:0]      o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_bf_valid,
    input  logic                  i_bf_ready,
    output logic [LOG2N-1:0]      o_bf_addr_a,
    output logic [LOG2N-1:0]      o_bf_addr_b,
    output logic [LOG2N-2:0]      o_tw_idx,
    output logic [STG_W-1:0]      o_stage,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int KW    = LOG2N - 1;
    localparam int DW    = 2 * LOG2N + KW;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);
    localparam logic [KW-1:0]    LAST_K   = '1;
    localparam logic [LOG2N-1:0] LAST_CNT = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_GAP,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [LOG2N-1:0]      r_cnt;
    logic [KW-1:0]         r_k;
    logic [STG_W-1:0]      r_s;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_in_ready;
    logic                  r_we;
    logic [LOG2N-1:0]      r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_bf_valid;
    logic [LOG2N-1:0]      r_addr_a;
    logic [LOG2N-1:0]      r_addr_b;
    logic [KW-1:0]         r_tw;
    logic                  r_busy;
    logic                  r_done;

    function automatic logic [LOG2N-1:0] bitrev(
        input logic [LOG2N-1:0] x
    );
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    // Inserting a zero at bit s of k yields addr_a; k's low s bits
    // scaled up to the ROM's N/2 resolution give the twiddle index.
    function automatic logic [DW-1:0] desc(
        input logic [KW-1:0]    k,
        input logic [STG_W-1:0] s
    );
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] half;
        logic [LOG2N-1:0] mask;
        logic [LOG2N-1:0] a;
        logic [KW-1:0]    pos;
        kk   = {1'b0, k};
        half = LOG2N'(1) << s;
        mask = half - LOG2N'(1);
        a    = ((kk & ~mask) << 1) | (kk & mask);
        pos  = k & KW'(mask);
        return {a, a + half, pos << (LOG2N - 1 - int'(s))};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_k        <= '0;
            r_s        <= '0;
            r_gap      <= '0;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_bf_valid <= 1'b0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_tw       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (i_start) begin
                    r_state    <= S_LOAD;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b1;
                end
                S_LOAD: if (i_in_valid && r_in_ready) begin
                    r_we    <= 1'b1;
                    r_waddr <= bitrev(r_cnt);
                    r_wdata <= i_in_data;
                    r_cnt   <= r_cnt + LOG2N'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_in_ready <= 1'b0;
                        r_k        <= '0;
                        r_s        <= '0;
                        r_state    <= S_COMPUTE;
                    end
                end
                S_COMPUTE: if (!r_bf_valid) begin
                    {r_addr_a, r_addr_b, r_tw} <= desc(r_k, r_s);
                    r_bf_valid <= 1'b1;
                end else if (i_bf_ready) begin
                    if (r_k != LAST_K) begin
                        r_k <= r_k + KW'(1);
                        {r_addr_a, r_addr_b, r_tw} <=
                            desc(r_k + KW'(1), r_s);
                    end else if (r_s == LAST_STG) begin
                        r_bf_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_k        <= '0;
                        r_s        <= '0;
                        r_state    <= S_DONE;
                    end else if (STAGE_GAP == 0) begin
                        r_k <= '0;
                        r_s <= r_s + STG_W'(1);
                        {r_addr_a, r_addr_b, r_tw} <=
                            desc('0, r_s + STG_W'(1));
                    end else begin
                        r_bf_valid <= 1'b0;
                        r_gap      <= '0;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: if (r_gap == GAP_LAST) begin
                    r_k        <= '0;
                    r_s        <= r_s + STG_W'(1);
                    {r_addr_a, r_addr_b, r_tw} <=
                        desc('0, r_s + STG_W'(1));
                    r_bf_valid <= 1'b1;
                    r_state    <= S_COMPUTE;
                end else begin
                    r_gap <= r_gap + GAP_W'(1);
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_we        = r_we;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_bf_valid  = r_bf_valid;
    assign o_bf_addr_a = r_addr_a;
    assign o_bf_addr_b = r_addr_b;
    assign o_tw_idx    = r_tw;
    assign o_stage     = r_s;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_fft_bram_addr_gen.sv
// tb_fft_bram_addr_gen: randomized bench for the FFT address generator,
// N=8 with STAGE_GAP 0 and 4, against a pair-enumeration reference.
module tb_fft_bram_addr_gen;
    localparam int L   = 3;
    localparam int N   = 8;
    localparam int H   = 4;
    localparam int TOT = 12;
    localparam int DW  = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic in_valid = 1'b0;
    logic bf_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    int sel = 0;

    logic a_rdy, a_we, a_bv, a_busy, a_done;
    logic [2:0] a_wa, a_ba, a_bb;
    logic [DW-1:0] a_wd;
    logic [1:0] a_tw, a_st;
    logic b_rdy, b_we, b_bv, b_busy, b_done;
    logic [2:0] b_wa, b_ba, b_bb;
    logic [DW-1:0] b_wd;
    logic [1:0] b_tw, b_st;
    logic m_rdy, m_we, m_bv, m_busy, m_done;
    logic [2:0] m_wa, m_ba, m_bb;
    logic [DW-1:0] m_wd;
    logic [1:0] m_tw, m_st;

    int n_cmp = 0;
    int n_bad = 0;
    int ea[TOT], eb[TOT], et[TOT], es[TOT];

    fft_bram_addr_gen #(.DATA_WIDTH(DW), .LOG2N(L), .STAGE_GAP(0)) u_g0 (
        .clk(clk), .rst_n(rst_n), .i_start(start_a),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(a_rdy),
        .o_we(a_we), .o_waddr(a_wa), .o_wdata(a_wd),
        .o_bf_valid(a_bv), .i_bf_ready(bf_ready),
        .o_bf_addr_a(a_ba), .o_bf_addr_b(a_bb), .o_tw_idx(a_tw),
        .o_stage(a_st), .o_busy(a_busy), .o_done(a_done)
    );

    fft_bram_addr_gen #(.DATA_WIDTH(DW), .LOG2N(L), .STAGE_GAP(4)) u_g4 (
        .clk(clk), .rst_n(rst_n), .i_start(start_b),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(b_rdy),
        .o_we(b_we), .o_waddr(b_wa), .o_wdata(b_wd),
        .o_bf_valid(b_bv), .i_bf_ready(bf_ready),
        .o_bf_addr_a(b_ba), .o_bf_addr_b(b_bb), .o_tw_idx(b_tw),
        .o_stage(b_st), .o_busy(b_busy), .o_done(b_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel == 1) begin
            m_rdy = b_rdy; m_we = b_we; m_wa = b_wa; m_wd = b_wd;
            m_bv = b_bv; m_ba = b_ba; m_bb = b_bb; m_tw = b_tw;
            m_st = b_st; m_busy = b_busy; m_done = b_done;
        end else begin
            m_rdy = a_rdy; m_we = a_we; m_wa = a_wa; m_wd = a_wd;
            m_bv = a_bv; m_ba = a_ba; m_bb = a_bb; m_tw = a_tw;
            m_st = a_st; m_busy = a_busy; m_done = a_done;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int brev(input int x);
        int r = 0;
        int v = x;
        for (int i = 0; i < L; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // Stage s pairs every address a whose s-th digit is 0 with a+2^s,
    // in ascending a; the twiddle is (a mod 2^s) scaled to N/2 entries.
    task automatic build();
        int idx = 0;
        for (int s = 0; s < L; s++) begin
            int half = 2 ** s;
            for (int a = 0; a < N; a++) begin
                if ((a / half) % 2 == 0) begin
                    ea[idx] = a;
                    eb[idx] = a + half;
                    et[idx] = (a % half) * (2 ** (L - 1 - s));
                    es[idx] = s;
                    idx++;
                end
            end
        end
    endtask

    task automatic drv_start(input bit v);
        start_a = v && (sel == 0);
        start_b = v && (sel == 1);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_rdy"}, m_rdy, 0);
        chk({t, "_we"}, m_we, 0);
        chk({t, "_waddr"}, m_wa, 0);
        chk({t, "_wdata"}, m_wd, 0);
        chk({t, "_bv"}, m_bv, 0);
        chk({t, "_a"}, m_ba, 0);
        chk({t, "_b"}, m_bb, 0);
        chk({t, "_tw"}, m_tw, 0);
        chk({t, "_stage"}, m_st, 0);
        chk({t, "_busy"}, m_busy, 0);
        chk({t, "_done"}, m_done, 0);
    endtask

    task automatic run(input bit stall, input bit poke, input int abort_at);
        int gap, j, idx, cyc, first, inv;
        bit acc, ingap;
        logic [DW-1:0] d[N];
        gap = (sel == 1) ? 4 : 0;
        for (int i = 0; i < N; i++) d[i] = DW'($urandom);
        drv_start(1'b1);
        @(negedge clk);
        drv_start(1'b0);
        chk("busy_up", m_busy, 1);
        chk("rdy_up", m_rdy, 1);
        j = 0; acc = 0; cyc = 0;
        forever begin
            if (acc) begin
                chk("we", m_we, 1);
                chk("waddr", m_wa, brev(j - 1));
                chk("wdata", m_wd, d[j-1]);
            end else begin
                chk("we_off", m_we, 0);
            end
            if (j == N) break;
            if (cyc > 200) begin
                chk("load_timeout", cyc, 0);
                return;
            end
            in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data = in_valid ? d[j] : DW'($urandom);
            acc = in_valid && m_rdy;
            if (acc) j++;
            drv_start(poke && $urandom_range(0, 3) == 0);
            @(negedge clk);
            cyc++;
        end
        chk("rdy_down", m_rdy, 0);
        in_valid = 1'b1;
        in_data = DW'($urandom);
        drv_start(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("over_beat", m_we, 0);
        idx = 0; cyc = 0; first = -1; inv = 0; ingap = 0;
        while (idx < TOT) begin
            if (cyc > 400) begin
                chk("bf_timeout", cyc, 0);
                return;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst_n = 1'b0;
                bf_ready = 1'b0;
                drv_start(1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                chk_reset("abort");
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk("abort_done", m_done, 0);
                end
                return;
            end
            chk("done_early", m_done, 0);
            if (m_bv) begin
                if (first < 0) begin
                    first = cyc;
                    chk("first_bf", first, 0);
                end
                if (ingap) begin
                    chk("gap_len", inv, gap);
                    ingap = 0;
                end
                chk("addr_a", m_ba, ea[idx]);
                chk("addr_b", m_bb, eb[idx]);
                chk("tw_idx", m_tw, et[idx]);
                chk("stage", m_st, es[idx]);
                bf_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (bf_ready) begin
                    idx++;
                    if (idx % H == 0) begin
                        ingap = 1;
                        inv = 0;
                    end
                end
            end else begin
                if (ingap) inv++;
                bf_ready = 1'($urandom_range(0, 1));
            end
            drv_start(poke && $urandom_range(0, 3) == 0);
            @(negedge clk);
            cyc++;
        end
        drv_start(1'b1);
        chk("done", m_done, 1);
        chk("busy_down", m_busy, 0);
        chk("bv_down", m_bv, 0);
        if (!stall) chk("duration", cyc - first, TOT + 2 * gap);
        @(negedge clk);
        drv_start(1'b0);
        chk("done_pulse", m_done, 0);
        chk("idle_busy", m_busy, 0);
        chk("idle_rdy", m_rdy, 0);
    endtask

    initial begin
        build();
        repeat (2) @(negedge clk);
        sel = 0; #1;
        chk_reset("rst0");
        sel = 1; #1;
        chk_reset("rst1");
        rst_n = 1'b1;
        @(negedge clk);
        sel = 0;
        run(1'b0, 1'b0, -1);
        run(1'b1, 1'b1, -1);
        sel = 1;
        run(1'b0, 1'b0, -1);
        run(1'b1, 1'b1, -1);
        run(1'b0, 1'b0, 6);
        run(1'b0, 1'b1, -1);
        sel = 0;
        run(1'b1, 1'b0, 6);
        run(1'b1, 1'b1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_bram_addr_gen.md
# fft_bram_addr_gen

Parametrised address/control generator for the radix-2 DIT FFT datapath. Accepts N = 2^LOG2N input samples on a valid/ready stream and writes them into the sample BRAM in bit-reversed order. It then sequences all LOG2N butterfly stages, issuing one butterfly per handshake: read address pair, twiddle index and stage number. It sits between the input stream, the dual-port sample BRAM and the butterfly unit, and replaces the per-stage index lookup table with on-the-fly address arithmetic.

## Interface
Parameters:
- DATA_WIDTH, 18, sample word width (real+imag packed by upstream).
- LOG2N, 10, log2 of FFT size; N = 2^LOG2N, BRAM depth = N; legal range 2..16.
- STAGE_GAP, 4, idle cycles inserted between stages to drain butterfly/write-back pipeline; 0 = back-to-back.
- STG_W, derived, max(1, ceil(log2(LOG2N))), stage index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- i_in_valid  in  1  input sample valid.
- i_in_data  in  DATA_WIDTH  input sample.
- o_in_ready  out  1  input ready (LOAD only).
- o_we  out  1  BRAM port-A write enable.
- o_waddr  out  LOG2N  BRAM write address (bit-reversed sample index).
- o_wdata  out  DATA_WIDTH  BRAM write data.
- o_bf_valid  out  1  butterfly descriptor valid.
- i_bf_ready  in  1  butterfly unit accepts descriptor.
- o_bf_addr_a  out  LOG2N  upper butterfly operand address.
- o_bf_addr_b  out  LOG2N  lower operand address (= a + 2^stage).
- o_tw_idx  out  LOG2N-1  twiddle ROM index.
- o_stage  out  STG_W  current stage, 0..LOG2N-1.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse on completion.

## Operation
- FSM: IDLE -> LOAD -> COMPUTE <-> GAP -> DONE -> IDLE.
- IDLE: i_start=1 -> LOAD, sample counter cnt=0. i_start in any other state is ignored.
- LOAD: o_in_ready=1. Each i_in_valid&o_in_ready beat registers o_we=1, o_waddr=bitrev_LOG2N(cnt), o_wdata=i_in_data; cnt++. Gaps in i_in_valid leave o_we=0 and hold cnt. After beat cnt=N-1 -> COMPUTE, stage=0, k=0.
- COMPUTE: butterfly k in 0..N/2-1, stage s: half=2^s, pos=k mod half, grp=k>>s; addr_a=grp*2^(s+1)+pos; addr_b=addr_a+half; tw_idx=pos<<(LOG2N-1-s). All arithmetic is unsigned LOG2N-bit with no overflow by construction.
- Descriptor stays stable while o_bf_valid=1 and i_bf_ready=0; k advances only on valid&ready.
- Last butterfly of stage s<LOG2N-1 accepted -> GAP (STAGE_GAP=0 skips GAP): o_bf_valid=0 for STAGE_GAP cycles, then s++, k=0, COMPUTE.
- Last butterfly of stage LOG2N-1 accepted -> DONE: o_done=1 for one cycle -> IDLE.
- rst_n=0 in any state: FSM -> IDLE, counters cleared; in-flight transform is abandoned, with no o_done.

## Timing
- Reset values: o_in_ready=0, o_we=0, o_waddr=0, o_wdata=0, o_bf_valid=0, o_bf_addr_a=0, o_bf_addr_b=0, o_tw_idx=0, o_stage=0, o_busy=0, o_done=0.
- All outputs are registered. o_busy and o_in_ready rise the cycle after i_start.
- Write latency: o_we appears 1 cycle after the accepted beat.
- o_in_ready falls the cycle after the Nth beat. No beat beyond N is accepted.
- First o_bf_valid appears the cycle after the LOAD->COMPUTE transition. With i_bf_ready tied high, one descriptor is issued per cycle.
- Compute duration with i_bf_ready=1: LOG2N*N/2 + (LOG2N-1)*STAGE_GAP cycles of COMPUTE/GAP. o_done pulses in the cycle after the final acceptance, and o_busy falls together with o_done.

## Test plan
- LOG2N=3, feed samples 0..7 back-to-back -> o_waddr sequence 0,4,2,6,1,5,3,7 with o_wdata 0..7, o_in_ready low after the 8th beat.
- LOG2N=3, i_bf_ready=1, STAGE_GAP=0 -> stage0 pairs (0,1)(2,3)(4,5)(6,7) with tw 0,0,0,0; stage1 pairs (0,2)(1,3)(4,6)(5,7) with tw 0,2,0,2; stage2 pairs (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3; o_done exactly 12 cycles after the first o_bf_valid.
- STAGE_GAP=4 -> exactly 4 cycles of o_bf_valid=0 between stages; total compute duration 12+2*4=20 cycles.
- Random i_bf_ready and i_in_valid gaps -> descriptors stable while stalled; same address/twiddle sequence as the unstalled run; no dropped or duplicated beat.
- i_start pulsed during LOAD and COMPUTE -> ignored, sequence unchanged. Back-to-back transforms (i_start on the o_done cycle ignored, next cycle accepted) -> second run identical.
- rst_n low mid-stage1 for 1 cycle -> all outputs at reset values next cycle, o_done never pulses; a new i_start then runs a full correct transform.
